bsg_vanilla_idiv_iter: RTL and testbench
========================================

Name: bsg_vanilla_idiv_iter

Overview:
- Parametrised iterative integer divider for the vanilla core EXE/long-latency path. Executes the idiv_op_e operations (eDIV, eDIVU, eREM, eREMU) on width_p-bit operands, one quotient bit per cycle.
- Carries a writeback register tag through to the result.
- Generalises the fixed-32-bit divide with:
  - a width parameter;
  - single-cycle early-out for divide-by-zero and signed overflow;
  - a kill input for squashing in-flight operations.

Parameters:
width_p, 32, operand/result width in bits (>=4)
reg_id_width_p, 5, width of the writeback tag (matches RV32_reg_addr_width_gp)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous reset, active-low
v_i  in  1  request valid
ready_o  out  1  divider can accept a request
op_i  in  2  idiv_op_e: 0=eDIV, 1=eDIVU, 2=eREM, 3=eREMU
dividend_i  in  width_p  rs1 value
divisor_i  in  width_p  rs2 value
rd_i  in  reg_id_width_p  destination tag
v_o  out  1  result valid
yumi_i  in  1  consumer takes result (only legal when v_o=1)
result_o  out  width_p  quotient or remainder per op
rd_o  out  reg_id_width_p  tag of the result
kill_i  in  1  abandon any in-flight or completed operation

Behaviour:
- One clock (clk_i). Reset is synchronous and active-low on reset_n_i.
- Reset values while reset_n_i=0 and the cycle after: state=IDLE, v_o=0, ready_o=0 during reset then 1, result_o=0, rd_o=0, counter=0.
- States: IDLE, CALC, DONE.
- ready_o=1 only in IDLE. Accept when v_i & ready_o & ~kill_i; latch op, rd, operand magnitudes, and sign flags.
- Signed ops (eDIV, eREM): operands are two's complement.
  - Quotient negative iff operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops: all sign flags = 0.
- Early-out, decided at accept, IDLE->DONE (v_o high the cycle after accept):
  - divisor==0: eDIV/eDIVU -> all ones; eREM/eREMU -> dividend_i unchanged.
  - eDIV/eREM with dividend = 1 followed by width_p-1 zeros and divisor = all ones: eDIV -> dividend_i; eREM -> 0.
- Normal path: IDLE->CALC; counter loads width_p.
  - Each CALC cycle performs one restoring step on the (width_p+1)-bit partial remainder and shifts in one quotient bit; counter decrements.
  - When counter reaches 1, go CALC->DONE with the sign-corrected result registered.
  - Accept at edge T gives v_o=1 from cycle T+width_p+1.
- DONE: v_o=1; result_o and rd_o are stable until consumed. DONE->IDLE on yumi_i, so ready_o=1 the next cycle. No back-to-back accept in the yumi cycle.
- Backpressure: v_o holds indefinitely while yumi_i=0.
- kill_i in any state: next state IDLE, v_o=0 next cycle. kill_i has priority over yumi_i and v_i; a kill in the accept cycle blocks the accept.
- Reset mid-operation discards all state with no output. A reset arriving the same cycle as yumi_i also wins.
- All arithmetic is width_p-bit, with a width_p+1 remainder internally. Negation is two's complement mod 2^width_p. Unsigned results never sign-correct.

Test Plan:
- eDIV 100/7, tag 3 -> v_o after 33 cycles, result 14, rd_o 3. eREM same operands -> 2.
- eDIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). eREM -> 0xFFFFFFFF (-1). eDIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. eREMU 0xFFFFFFFF/16 -> 0xF.
- Divisor 0, dividend 0x1234: eDIV/eDIVU -> 0xFFFFFFFF and eREM/eREMU -> 0x1234, each with v_o one cycle after accept. Overflow 0x80000000 / 0xFFFFFFFF: eDIV -> 0x80000000, eREM -> 0, each with one-cycle latency.
- Backpressure: hold yumi_i=0 for 10 cycles after v_o -> result and rd stable, ready_o=0. Assert yumi_i -> ready_o=1 next cycle, new request accepted.
- Kill at CALC cycle 5 -> v_o never asserts for that op, ready_o=1 next cycle; the following eDIVU 9/3 returns 3. Kill in DONE with yumi_i=1 -> treated as kill. reset_n_i=0 mid-CALC -> IDLE, no output.
- width_p=8 instance: eDIV 0x80/0xFF -> 0x80 in one cycle. eDIV 0x9C (-100)/7 -> 0xF2 (-14), v_o 9 cycles after accept. Random signed/unsigned sweep matches a reference model.

Source files
------------

// File: rtl/bsg_vanilla_idiv_iter.sv
// Iterative restoring divider: one quotient bit per cycle.
// Early-out for divide-by-zero and signed overflow; kill squashes.
module bsg_vanilla_idiv_iter #(
  parameter int width_p        = 32,
  parameter int reg_id_width_p = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [1:0]                op_i,
  input  logic [width_p-1:0]        dividend_i,
  input  logic [width_p-1:0]        divisor_i,
  input  logic [reg_id_width_p-1:0] rd_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [width_p-1:0]        result_o,
  output logic [reg_id_width_p-1:0] rd_o,
  input  logic                      kill_i
);

  typedef enum logic [1:0] {
    eIDLE,
    eCALC,
    eDONE
  } state_e;

  localparam int cnt_w_lp = $clog2(width_p + 1);
  localparam logic [width_p-1:0] min_neg_lp =
    {1'b1, {(width_p-1){1'b0}}};

  state_e                    state_q;
  logic [cnt_w_lp-1:0]       cnt_q;
  logic [width_p-1:0]        quot_q;
  logic [width_p-1:0]        dvs_q;
  logic [width_p-1:0]        rem_q;
  logic [width_p-1:0]        result_q;
  logic [reg_id_width_p-1:0] rd_q;
  logic                      neg_quot_q;
  logic                      neg_rem_q;
  logic                      is_rem_q;
  logic                      ready_q;
  logic                      v_q;

  logic                      sign_a;
  logic                      sign_b;
  logic                      div_zero;
  logic                      ovf;
  logic [width_p-1:0]        mag_a;
  logic [width_p-1:0]        mag_b;
  logic [width_p-1:0]        early_res;

  logic [width_p:0]          diff_d;
  logic                      qbit_d;
  logic [width_p-1:0]        rem_d;
  logic [width_p-1:0]        quot_d;
  logic [width_p-1:0]        res_d;

  // op_i[0]=1 selects unsigned, op_i[1]=1 selects remainder
  always_comb begin
    sign_a    = ~op_i[0] & dividend_i[width_p-1];
    sign_b    = ~op_i[0] & divisor_i[width_p-1];
    mag_a     = sign_a ? -dividend_i : dividend_i;
    mag_b     = sign_b ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = ~op_i[0]
              & (dividend_i == min_neg_lp)
              & (&divisor_i);
    early_res = '0;
    if (div_zero)
      early_res = op_i[1] ? dividend_i : '1;
    else if (ovf)
      early_res = op_i[1] ? '0 : dividend_i;
  end

  // restoring step on the shifted (width_p+1)-bit partial remainder
  always_comb begin
    diff_d = {rem_q, quot_q[width_p-1]}
           - {1'b0, dvs_q};
    qbit_d = ~diff_d[width_p];
    rem_d  = qbit_d
           ? diff_d[width_p-1:0]
           : {rem_q[width_p-2:0], quot_q[width_p-1]};
    quot_d = {quot_q[width_p-2:0], qbit_d};
    if (is_rem_q)
      res_d = neg_rem_q ? -rem_d : rem_d;
    else
      res_d = neg_quot_q ? -quot_d : quot_d;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= eIDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      ready_q    <= 1'b0;
      v_q        <= 1'b0;
    end else if (kill_i) begin
      state_q <= eIDLE;
      v_q     <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        eIDLE: begin
          if (v_i & ready_q) begin
            rd_q       <= rd_i;
            is_rem_q   <= op_i[1];
            neg_quot_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            ready_q    <= 1'b0;
            if (div_zero | ovf) begin
              state_q  <= eDONE;
              result_q <= early_res;
              v_q      <= 1'b1;
            end else begin
              state_q <= eCALC;
              cnt_q   <= cnt_w_lp'(width_p);
              quot_q  <= mag_a;
              dvs_q   <= mag_b;
              rem_q   <= '0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        eCALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - cnt_w_lp'(1);
          if (cnt_q == cnt_w_lp'(1)) begin
            state_q  <= eDONE;
            result_q <= res_d;
            v_q      <= 1'b1;
          end
        end
        eDONE: begin
          if (yumi_i) begin
            state_q <= eIDLE;
            v_q     <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= eIDLE;
          v_q     <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign v_o      = v_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_bsg_vanilla_idiv_iter.sv
// Bench for bsg_vanilla_idiv_iter: 32-bit and 8-bit instances
// checked against an arithmetic reference model.
module tb_bsg_vanilla_idiv_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        v_i = 1'b0, yumi_i = 1'b0, kill_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [4:0]  rd_i = '0;
  logic        ready_o, v_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  logic        v8_i = 1'b0, yumi8_i = 1'b0, kill8_i = 1'b0;
  logic [1:0]  op8_i = '0;
  logic [7:0]  a8_i = '0, b8_i = '0;
  logic        ready8_o, v8_o;
  logic [7:0]  result8_o;
  logic [4:0]  rd8_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_vanilla_idiv_iter #(.width_p(32), .reg_id_width_p(5)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .dividend_i(a_i), .divisor_i(b_i), .rd_i(rd_i),
    .v_o(v_o), .yumi_i(yumi_i), .result_o(result_o),
    .rd_o(rd_o), .kill_i(kill_i)
  );

  bsg_vanilla_idiv_iter #(.width_p(8), .reg_id_width_p(5)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v8_i), .ready_o(ready8_o), .op_i(op8_i),
    .dividend_i(a8_i), .divisor_i(b8_i), .rd_i(5'd9),
    .v_o(v8_o), .yumi_i(yumi8_i), .result_o(result8_o),
    .rd_o(rd8_o), .kill_i(kill8_i)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // RISC-V division semantics on w-bit values
  function automatic logic [31:0] model(int w, logic [1:0] op,
                                        logic [31:0] a, logic [31:0] b);
    longint m, ua, ub, sa, sb, q, r;
    logic [63:0] res;
    m  = (longint'(1) << w) - 1;
    ua = {32'b0, a} & m;
    ub = {32'b0, b} & m;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    if (ub == 0) res = op[1] ? ua : m;
    else if (!op[0] && sa == -(longint'(1) << (w-1)) && sb == -1)
      res = op[1] ? 64'd0 : ua;
    else begin
      q   = op[0] ? ua / ub : sa / sb;
      r   = op[0] ? ua % ub : sa % sb;
      res = (op[1] ? r : q) & m;
    end
    return res[31:0];
  endfunction

  function automatic bit early(int w, logic [1:0] op,
                               logic [31:0] a, logic [31:0] b);
    logic [31:0] m, mn;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    mn = 32'd1 << (w - 1);
    return ((b & m) == 0) ||
           (!op[0] && (a & m) == mn && (b & m) == m);
  endfunction

  // scoreboard monitor for the 32-bit instance
  bit          exp_v = 0, seen = 0, post_rst = 0;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  int          lat = 0, exp_lat = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_v = 0; seen = 0; post_rst = 1;
    end else begin
      if (exp_v) begin
        lat++;
        if (v_o) begin
          if (!seen) chk("latency", lat, exp_lat);
          seen = 1;
          chk("mon_result", result_o, exp_res);
          chk("mon_rd", rd_o, exp_rd);
        end else if (seen) chk("v_dropped", v_o, 1);
        else if (lat == exp_lat) chk("v_late", v_o, 1);
      end else begin
        chk("v_idle", v_o, 0);
      end
      if (!post_rst) chk("ready", ready_o, !exp_v);
      post_rst = 0;
      if (kill_i || (seen && yumi_i)) begin
        exp_v = 0; seen = 0;
      end
      if (v_i && ready_o && !kill_i) begin
        exp_v   = 1; seen = 0; lat = 0;
        exp_res = model(32, op_i, a_i, b_i);
        exp_rd  = rd_i;
        exp_lat = early(32, op_i, a_i, b_i) ? 1 : 33;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start32(logic [1:0] op, logic [31:0] a,
                         logic [31:0] b, logic [4:0] rd);
    int n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
    v_i = 1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    tick();
    v_i = 0;
  endtask

  task automatic wait_v32();
    int n = 0;
    while (!v_o && n < 100) begin tick(); n++; end
    if (!v_o) chk("v_timeout", v_o, 1);
  endtask

  task automatic do_op32(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, int hold,
                         output logic [31:0] res);
    start32(op, a, b, rd);
    wait_v32();
    repeat (hold) tick();
    res = result_o;
    yumi_i = 1;
    tick();
    yumi_i = 0;
  endtask

  task automatic do_op8(logic [1:0] op, logic [7:0] a, logic [7:0] b,
                        output logic [7:0] res);
    int n = 0;
    while (!ready8_o && n < 100) begin tick(); n++; end
    v8_i = 1; op8_i = op; a8_i = a; b8_i = b;
    tick();
    v8_i = 0; n = 1;
    while (!v8_o && n < 100) begin tick(); n++; end
    chk("lat8", n, early(8, op, {24'b0, a}, {24'b0, b}) ? 1 : 9);
    chk("res8", {24'b0, result8_o},
        model(8, op, {24'b0, a}, {24'b0, b}));
    chk("rd8", {27'b0, rd8_o}, 9);
    res = result8_o;
    yumi8_i = 1;
    tick();
    yumi8_i = 0;
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  r8;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;

    chk("model_div", model(32, 0, 100, 7), 14);
    chk("model_rem", model(32, 2, 100, 7), 2);
    chk("model_sdiv", model(32, 0, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("model_srem", model(32, 2, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("model_div8", model(8, 0, 32'h9C, 7), 32'hF2);

    repeat (2) tick();
    chk("rst_v", v_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", rd_o, 0);
    reset_n = 1;
    tick();
    chk("post_rst_ready", ready_o, 1);

    do_op32(0, 100, 7, 3, 0, r);           chk("div_100_7", r, 14);
    do_op32(2, 100, 7, 3, 0, r);           chk("rem_100_7", r, 2);
    do_op32(0, 32'hFFFF_FFF9, 2, 1, 0, r); chk("div_m7_2", r, 32'hFFFF_FFFD);
    do_op32(2, 32'hFFFF_FFF9, 2, 1, 0, r); chk("rem_m7_2", r, 32'hFFFF_FFFF);
    do_op32(1, 32'hFFFF_FFFF, 1, 2, 0, r); chk("divu_max_1", r, 32'hFFFF_FFFF);
    do_op32(3, 32'hFFFF_FFFF, 16, 2, 0, r); chk("remu_max_16", r, 32'hF);
    do_op32(0, 32'h1234, 0, 4, 0, r);      chk("div_by0", r, 32'hFFFF_FFFF);
    do_op32(1, 32'h1234, 0, 4, 0, r);      chk("divu_by0", r, 32'hFFFF_FFFF);
    do_op32(2, 32'h1234, 0, 4, 0, r);      chk("rem_by0", r, 32'h1234);
    do_op32(3, 32'h1234, 0, 4, 0, r);      chk("remu_by0", r, 32'h1234);
    do_op32(0, 32'h8000_0000, 32'hFFFF_FFFF, 6, 0, r);
    chk("div_ovf", r, 32'h8000_0000);
    do_op32(2, 32'h8000_0000, 32'hFFFF_FFFF, 6, 0, r);
    chk("rem_ovf", r, 0);

    // backpressure
    start32(0, 100, 7, 3);
    wait_v32();
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", result_o, 14);
      chk("bp_rd", rd_o, 3);
      chk("bp_ready", ready_o, 0);
      tick();
    end
    yumi_i = 1;
    tick();
    yumi_i = 0;
    chk("bp_ready_after", ready_o, 1);
    do_op32(1, 50, 5, 8, 0, r); chk("after_bp", r, 10);

    // kill at CALC cycle 5
    start32(1, 1000, 7, 5);
    repeat (4) tick();
    kill_i = 1;
    tick();
    kill_i = 0;
    chk("kill_ready", ready_o, 1);
    chk("kill_v", v_o, 0);
    do_op32(1, 9, 3, 7, 0, r); chk("after_kill", r, 3);

    // kill blocks an accept in the same cycle
    v_i = 1; op_i = 0; a_i = 77; b_i = 7; rd_i = 2; kill_i = 1;
    tick();
    v_i = 0; kill_i = 0;
    chk("kill_acc_ready", ready_o, 1);
    repeat (2) tick();
    chk("kill_acc_v", v_o, 0);

    // kill with yumi in DONE
    start32(0, 1, 0, 10);
    wait_v32();
    kill_i = 1; yumi_i = 1;
    tick();
    kill_i = 0; yumi_i = 0;
    chk("kill_done_v", v_o, 0);
    chk("kill_done_ready", ready_o, 1);

    // reset mid-CALC
    start32(1, 12345, 11, 12);
    repeat (5) tick();
    reset_n = 0;
    tick();
    chk("midrst_v", v_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_result", result_o, 0);
    reset_n = 1;
    tick();
    chk("midrst_ready_after", ready_o, 1);
    repeat (40) tick();
    chk("midrst_no_out", v_o, 0);

    // reset beats yumi
    start32(3, 3, 0, 13);
    wait_v32();
    reset_n = 0; yumi_i = 1;
    tick();
    yumi_i = 0;
    chk("rst_yumi_v", v_o, 0);
    reset_n = 1;
    tick();

    // random 32-bit sweep with random consumer delay
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 5) b = $urandom_range(1, 20);
      else b = $urandom >> $urandom_range(0, 31);
      do_op32(op, a, b, 5'($urandom), $urandom_range(0, 3), r);
    end

    // 8-bit instance
    do_op8(0, 8'h80, 8'hFF, r8); chk("w8_ovf", {24'b0, r8}, 32'h80);
    do_op8(0, 8'h9C, 8'h07, r8); chk("w8_div", {24'b0, r8}, 32'hF2);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 8 == 0) ? 32'd0 : $urandom;
      do_op8(2'($urandom_range(0, 3)), a[7:0], b[7:0], r8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
